// File: rtl/hazard_ctrl_if.sv
// Pipeline sequencing bundle between the 5-stage datapath and hazard_ctrl.
// master = datapath side, slave = hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_rd;
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             IF_ID_use_rs1;
    logic             IF_ID_use_rs2;
    logic             ID_EX_is_mdu;
    logic             mdu_done;
    logic             EX_branch_taken;
    logic             mem_stall;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             EX_MEM_Flush;
    logic             MEM_WB_Write;
    logic             mdu_start;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
               IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_is_mdu, mdu_done,
               EX_branch_taken, mem_stall,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, mdu_start,
               mdu_timeout, stall_cycles
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
               IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_is_mdu, mdu_done,
               EX_branch_taken, mem_stall,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, mdu_start,
               mdu_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, MUL/DIV occupancy, branch flush,
// data-memory wait states, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned       CNT_MW    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [CNT_MW-1:0] MDU_LAST  = CNT_MW'(MDU_TIMEOUT - 1);
    localparam logic [CNT_MW-1:0] MDU_ONE   = CNT_MW'(1);
    localparam logic [CNT_W-1:0]  STALL_ONE = CNT_W'(1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MDU_BUSY = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    logic [1:0]        state, state_nx;
    logic [1:0]        ret_state, ret_nx;
    logic [1:0]        eff_state;
    logic              done_pend, pend_nx;
    logic [CNT_MW-1:0] mdu_cnt, cnt_nx;
    logic              timeout_q, timeout_set;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, exmem_flush, memwb_write, start;

    assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_rd != 5'd0) &&
                      ((hz.IF_ID_use_rs1 && (hz.ID_EX_rd == hz.IF_ID_rs1)) ||
                       (hz.IF_ID_use_rs2 && (hz.ID_EX_rd == hz.IF_ID_rs2)));

    // Leaving MEM_WAIT applies the saved state's rules in the same cycle.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        memwb_write = 1'b1;
        start       = 1'b0;
        state_nx    = state;
        ret_nx      = ret_state;
        pend_nx     = done_pend;
        cnt_nx      = mdu_cnt;
        timeout_set = 1'b0;

        if (hz.mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            state_nx    = MEM_WAIT;
            if (state != MEM_WAIT)
                ret_nx = state;
            // A done pulse arriving while frozen is remembered for release.
            if (hz.mdu_done && (eff_state == MDU_BUSY))
                pend_nx = 1'b1;
        end else begin
            case (eff_state)
                MDU_BUSY: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                    cnt_nx      = mdu_cnt + MDU_ONE;
                    state_nx    = MDU_BUSY;
                    if (hz.mdu_done || done_pend) begin
                        exmem_flush = 1'b0;
                        pend_nx     = 1'b0;
                        state_nx    = RUN;
                    end else if (mdu_cnt == MDU_LAST) begin
                        timeout_set = 1'b1;
                        state_nx    = RUN;
                    end
                end
                default: begin
                    state_nx = RUN;
                    if (hz.ID_EX_is_mdu) begin
                        start       = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_nx      = '0;
                        state_nx    = MDU_BUSY;
                    end else if (hz.EX_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            done_pend <= 1'b0;
            mdu_cnt   <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            done_pend <= pend_nx;
            mdu_cnt   <= cnt_nx;
            timeout_q <= timeout_q | timeout_set;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_ONE;
        end
    end

    assign hz.PCWrite      = pc_write;
    assign hz.IF_ID_Write  = ifid_write;
    assign hz.IF_ID_Flush  = ifid_flush;
    assign hz.ID_EX_Write  = idex_write;
    assign hz.ID_EX_Flush  = idex_flush;
    assign hz.EX_MEM_Write = exmem_write;
    assign hz.EX_MEM_Flush = exmem_flush;
    assign hz.MEM_WB_Write = memwb_write;
    assign hz.mdu_start    = start;
    assign hz.mdu_timeout  = timeout_q;
    assign hz.stall_cycles = stall_cnt;
endmodule
